// File: rtl/am2901_useq.sv
// Microprogram sequencer and pipeline register feeding Am2901_top.
// Picks the next microaddress from the pipelined word, ALU flags, return stack and loop counter.
module am2901_useq #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [ADDR_W-1:0] o_uaddr,
    input  logic [ADDR_W+26:0] i_uword,
    input  logic              i_f_0,
    input  logic              i_cn4,
    input  logic              i_ovr,
    input  logic              i_start,
    output logic [8:0]        o_i,
    output logic [3:0]        o_a,
    output logic [3:0]        o_b,
    output logic [3:0]        o_datain,
    output logic              o_cn,
    output logic [ADDR_W-1:0] o_cur,
    output logic              o_halted,
    output logic              o_stk_err
);

    localparam int WORD_W   = ADDR_W + 27;
    localparam int D_LSB    = 1;
    localparam int B_LSB    = 5;
    localparam int A_LSB    = 9;
    localparam int I_LSB    = 13;
    localparam int BR_LSB   = 22;
    localparam int COND_LSB = 22 + ADDR_W;
    localparam int SEQ_LSB  = 24 + ADDR_W;
    localparam int SP_W     = $clog2(STACK_DEPTH + 1);

    localparam logic [8:0]        NOP_I    = 9'b001_000_111;
    localparam logic [WORD_W-1:0] NOP_WORD = {3'b000, 2'b00, {ADDR_W{1'b0}}, NOP_I, 13'b0};
    localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        SEQ_CONT  = 3'b000,
        SEQ_JUMP  = 3'b001,
        SEQ_CALL  = 3'b010,
        SEQ_RET   = 3'b011,
        SEQ_LDCNT = 3'b100,
        SEQ_LOOP  = 3'b101,
        SEQ_HALT  = 3'b110,
        SEQ_RSVD  = 3'b111
    } seq_e;

    logic [WORD_W-1:0] r_pipe;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_cnt;
    logic [SP_W-1:0]   r_sp;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic              r_err;

    seq_e              w_seq;
    logic [1:0]        w_cond_sel;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_nxt;
    logic [ADDR_W-1:0] w_tos;
    logic [ADDR_W-1:0] w_uaddr;
    logic              w_cond;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_err;
    logic              w_cnt_ld;
    logic              w_cnt_dec;
    logic              w_halted;

    assign w_seq      = seq_e'(r_pipe[SEQ_LSB +: 3]);
    assign w_cond_sel = r_pipe[COND_LSB +: 2];
    assign w_br       = r_pipe[BR_LSB +: ADDR_W];
    assign w_nxt      = r_cur + ADDR_W'(1);
    assign w_full     = (r_sp == SP_FULL);
    assign w_empty    = (r_sp == '0);

    always_comb begin
        w_cond = 1'b1;
        case (w_cond_sel)
            2'b00:   w_cond = 1'b1;
            2'b01:   w_cond = i_f_0;
            2'b10:   w_cond = i_cn4;
            default: w_cond = i_ovr;
        endcase
    end

    // Top of stack is the entry just below the pointer; a loop avoids a narrow index.
    always_comb begin
        w_tos = '0;
        for (int k = 0; k < STACK_DEPTH; k++) begin
            if (r_sp == SP_W'(k + 1)) begin
                w_tos = r_stack[k];
            end
        end
    end

    always_comb begin
        w_uaddr   = w_nxt;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err     = 1'b0;
        w_cnt_ld  = 1'b0;
        w_cnt_dec = 1'b0;
        w_halted  = 1'b0;
        case (w_seq)
            SEQ_JUMP: begin
                if (w_cond) begin
                    w_uaddr = w_br;
                end
            end
            SEQ_CALL: begin
                // The branch is taken even when the push is dropped on a full stack.
                if (w_cond) begin
                    w_uaddr = w_br;
                    if (w_full) begin
                        w_err = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
            end
            SEQ_RET: begin
                if (w_cond) begin
                    if (w_empty) begin
                        w_err = 1'b1;
                    end else begin
                        w_uaddr = w_tos;
                        w_pop   = 1'b1;
                    end
                end
            end
            SEQ_LDCNT: begin
                w_cnt_ld = 1'b1;
            end
            SEQ_LOOP: begin
                if (r_cnt != '0) begin
                    w_cnt_dec = 1'b1;
                    w_uaddr   = w_br;
                end
            end
            SEQ_HALT: begin
                if (!i_start) begin
                    w_uaddr  = r_cur;
                    w_halted = 1'b1;
                end
            end
            default: begin
                w_uaddr = w_nxt;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= NOP_WORD;
            r_cur  <= '1;
            r_cnt  <= '0;
            r_sp   <= '0;
            r_err  <= 1'b0;
            for (int k = 0; k < STACK_DEPTH; k++) begin
                r_stack[k] <= '0;
            end
        end else begin
            r_pipe <= i_uword;
            r_cur  <= w_uaddr;
            if (w_push) begin
                for (int k = 0; k < STACK_DEPTH; k++) begin
                    if (r_sp == SP_W'(k)) begin
                        r_stack[k] <= w_nxt;
                    end
                end
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SP_W'(1);
            end
            if (w_cnt_ld) begin
                r_cnt <= w_br;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - ADDR_W'(1);
            end
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_uaddr   = w_uaddr;
    assign o_cur     = r_cur;
    assign o_i       = w_halted ? NOP_I : r_pipe[I_LSB +: 9];
    assign o_a       = r_pipe[A_LSB +: 4];
    assign o_b       = r_pipe[B_LSB +: 4];
    assign o_datain  = r_pipe[D_LSB +: 4];
    assign o_cn      = r_pipe[0];
    assign o_halted  = w_halted;
    assign o_stk_err = r_err;

endmodule
